// File: rtl/fft_scale_sat_ctrl.sv
// ---------------------------------------------------------------------------
// fft_scale_sat_ctrl
// Block-floating-point scaling and saturation for radix-2^2 FFT stage outputs.
// Each complex sample is arithmetically right-shifted with round-half-up by the
// frame's current shift, then saturated from IN_WIDTH to OUT_WIDTH bits.
// Saturation events are counted per frame. In auto mode the shift adapts at
// frame boundaries: it goes up after an overflowing frame and down after a frame
// that had headroom.
//
// Ports
//   i_clk         rising-edge clock
//   i_rst         asynchronous active-high reset
//   i_valid       input sample valid (no backpressure)
//   i_real/i_imag input components, IN_WIDTH two's complement
//   i_auto        1 = adaptive shift, 0 = manual shift from i_shift_cfg
//   i_shift_cfg   manual shift, takes effect at the next frame start
//   i_clr_sticky  clears o_ovf_sticky (a simultaneous saturation wins)
//   o_valid       i_valid delayed by two cycles
//   o_real/o_imag scaled, saturated components, OUT_WIDTH
//   o_shift       exponent tag: the shift applied to this output sample
//   o_frame_end   last sample of a frame, qualified by o_valid
//   o_ovf_cnt     saturated-sample count of the last completed frame
//   o_ovf_sticky  set by any saturated output sample
// ---------------------------------------------------------------------------
module fft_scale_sat_ctrl #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 12,
    parameter int FRAME_LEN = 64,
    parameter int MAX_SHIFT = 4,
    parameter int SW        = 3,
    parameter int CW        = 7
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [IN_WIDTH-1:0]  i_real,
    input  logic [IN_WIDTH-1:0]  i_imag,
    input  logic                 i_auto,
    input  logic [SW-1:0]        i_shift_cfg,
    input  logic                 i_clr_sticky,
    output logic                 o_valid,
    output logic [OUT_WIDTH-1:0] o_real,
    output logic [OUT_WIDTH-1:0] o_imag,
    output logic [SW-1:0]        o_shift,
    output logic                 o_frame_end,
    output logic [CW-1:0]        o_ovf_cnt,
    output logic                 o_ovf_sticky
);

    localparam int W1   = IN_WIDTH + 1;
    localparam int CNTW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(FRAME_LEN - 1);
    localparam logic [SW-1:0]   MAX_S    = SW'(MAX_SHIFT);
    localparam logic [SW-1:0]   ONE_S    = SW'(1);

    // Output range and the half-range used as the headroom test.
    localparam logic signed [W1-1:0] SAT_HI  = {{(W1-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [W1-1:0] SAT_LO  = {{(W1-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [W1-1:0] HEAD_HI = {{(W1-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-2){1'b1}}};
    localparam logic signed [W1-1:0] HEAD_LO = {{(W1-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-2){1'b0}}};

    // Round-half-up arithmetic right shift, one guard bit so the rounding add cannot wrap.
    function automatic logic signed [W1-1:0] scale_fn(
        input logic [IN_WIDTH-1:0] x,
        input logic [SW-1:0]       s
    );
        logic signed [W1-1:0] rnd;
        logic signed [W1-1:0] v;
        if (s != {SW{1'b0}}) begin
            rnd = $signed(W1'(1) << (s - ONE_S));
        end else begin
            rnd = {W1{1'b0}};
        end
        v = $signed({x[IN_WIDTH-1], x}) + rnd;
        return v >>> s;
    endfunction

    function automatic logic is_sat_fn(input logic signed [W1-1:0] y);
        return (y > SAT_HI) || (y < SAT_LO);
    endfunction

    function automatic logic is_head_fn(input logic signed [W1-1:0] y);
        return (y >= HEAD_LO) && (y <= HEAD_HI);
    endfunction

    function automatic logic [OUT_WIDTH-1:0] saturate_fn(input logic signed [W1-1:0] y);
        logic [OUT_WIDTH-1:0] r;
        if (y > SAT_HI) begin
            r = SAT_HI[OUT_WIDTH-1:0];
        end else if (y < SAT_LO) begin
            r = SAT_LO[OUT_WIDTH-1:0];
        end else begin
            r = y[OUT_WIDTH-1:0];
        end
        return r;
    endfunction

    // Frame state
    logic [CNTW-1:0]      cnt_r;
    logic [SW-1:0]        cur_shift_r;
    logic                 first_r;      // no sample accepted since reset
    logic [CW-1:0]        ovf_acc_r;
    logic                 head_acc_r;

    // Stage-1 registers
    logic                 valid1_r;
    logic signed [W1-1:0] yr1_r;
    logic signed [W1-1:0] yi1_r;
    logic                 sat1_r;
    logic                 last1_r;
    logic [CW-1:0]        cnt1_r;
    logic [SW-1:0]        shift1_r;

    // Combinational stage-1 / frame-control signals
    logic [SW-1:0]        min_cfg_s;
    logic [SW-1:0]        eff_shift_s;
    logic signed [W1-1:0] yr_s;
    logic signed [W1-1:0] yi_s;
    logic                 sat_s;
    logic                 head_s;
    logic                 sample0_s;
    logic                 last_s;
    logic [CW-1:0]        ovf_next_s;
    logic                 head_next_s;
    logic [SW-1:0]        shift_next_s;
    logic [CNTW-1:0]      cnt_next_s;

    // Scaling, sample flags, frame accumulation and next-shift decision.
    always_comb begin
        min_cfg_s    = (i_shift_cfg > MAX_S) ? MAX_S : i_shift_cfg;
        // The very first sample after reset takes the manual shift immediately.
        eff_shift_s  = (first_r && !i_auto) ? min_cfg_s : cur_shift_r;
        yr_s         = scale_fn(i_real, eff_shift_s);
        yi_s         = scale_fn(i_imag, eff_shift_s);
        sat_s        = is_sat_fn(yr_s) || is_sat_fn(yi_s);
        head_s       = is_head_fn(yr_s) && is_head_fn(yi_s);
        sample0_s    = (cnt_r == {CNTW{1'b0}});
        last_s       = (cnt_r == LAST_IDX);
        ovf_next_s   = (sample0_s ? {CW{1'b0}} : ovf_acc_r) + CW'(sat_s);
        head_next_s  = (sample0_s ? 1'b1 : head_acc_r) && head_s;
        shift_next_s = cur_shift_r;
        cnt_next_s   = cnt_r;
        if (i_valid) begin
            cnt_next_s   = last_s ? {CNTW{1'b0}} : (cnt_r + CNTW'(1));
            shift_next_s = eff_shift_s;
            if (last_s) begin
                if (!i_auto) begin
                    shift_next_s = min_cfg_s;
                end else if ((ovf_next_s != {CW{1'b0}}) && (eff_shift_s < MAX_S)) begin
                    shift_next_s = eff_shift_s + ONE_S;
                end else if ((ovf_next_s == {CW{1'b0}}) && head_next_s &&
                             (eff_shift_s != {SW{1'b0}})) begin
                    shift_next_s = eff_shift_s - ONE_S;
                end else begin
                    shift_next_s = eff_shift_s;
                end
            end else begin
                shift_next_s = eff_shift_s;
            end
        end else begin
            cnt_next_s   = cnt_r;
            shift_next_s = cur_shift_r;
        end
    end

    // Frame counter, accumulators and current shift.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_r       <= {CNTW{1'b0}};
            cur_shift_r <= {SW{1'b0}};
            first_r     <= 1'b1;
            ovf_acc_r   <= {CW{1'b0}};
            head_acc_r  <= 1'b1;
        end else begin
            cnt_r       <= cnt_next_s;
            cur_shift_r <= shift_next_s;
            if (i_valid) begin
                first_r    <= 1'b0;
                ovf_acc_r  <= ovf_next_s;
                head_acc_r <= head_next_s;
            end
        end
    end

    // Stage 1: scaled value, flags and the frame count carried with the last sample.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid1_r <= 1'b0;
            yr1_r    <= {W1{1'b0}};
            yi1_r    <= {W1{1'b0}};
            sat1_r   <= 1'b0;
            last1_r  <= 1'b0;
            cnt1_r   <= {CW{1'b0}};
            shift1_r <= {SW{1'b0}};
        end else begin
            valid1_r <= i_valid;
            yr1_r    <= yr_s;
            yi1_r    <= yi_s;
            sat1_r   <= i_valid && sat_s;
            last1_r  <= i_valid && last_s;
            cnt1_r   <= ovf_next_s;
            shift1_r <= eff_shift_s;
        end
    end

    // Stage 2: saturated outputs and frame status.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid      <= 1'b0;
            o_real       <= {OUT_WIDTH{1'b0}};
            o_imag       <= {OUT_WIDTH{1'b0}};
            o_shift      <= {SW{1'b0}};
            o_frame_end  <= 1'b0;
            o_ovf_cnt    <= {CW{1'b0}};
            o_ovf_sticky <= 1'b0;
        end else begin
            o_valid     <= valid1_r;
            o_real      <= saturate_fn(yr1_r);
            o_imag      <= saturate_fn(yi1_r);
            o_shift     <= shift1_r;
            o_frame_end <= valid1_r && last1_r;
            if (valid1_r && last1_r) begin
                o_ovf_cnt <= cnt1_r;
            end
            // A saturating sample beats a concurrent clear.
            if (valid1_r && sat1_r) begin
                o_ovf_sticky <= 1'b1;
            end else if (i_clr_sticky) begin
                o_ovf_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_scale_sat_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_scale_sat_ctrl
// Directed bench for fft_scale_sat_ctrl with FRAME_LEN = 8. Every driven sample
// pushes a hand-computed expected output record; a negedge monitor pops and
// compares each o_valid beat (data, shift tag, frame end, frame count, sticky
// flag and latency). Reset and sticky-clear behaviour are checked directly.
// ---------------------------------------------------------------------------
module tb_fft_scale_sat_ctrl;

    logic               clk;
    logic               rst;
    logic               valid;
    logic [15:0]        re;
    logic [15:0]        im;
    logic               auto_m;
    logic [2:0]         cfg;
    logic               clr;
    logic               o_valid;
    logic [11:0]        o_real;
    logic [11:0]        o_imag;
    logic [2:0]         o_shift;
    logic               o_frame_end;
    logic [6:0]         o_ovf_cnt;
    logic               o_ovf_sticky;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int re;
        int im;
        int sh;
        int fe;
        int cnt;
        int stk;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t me;

    fft_scale_sat_ctrl #(
        .IN_WIDTH (16),
        .OUT_WIDTH(12),
        .FRAME_LEN(8),
        .MAX_SHIFT(4),
        .SW       (3),
        .CW       (7)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_real      (re),
        .i_imag      (im),
        .i_auto      (auto_m),
        .i_shift_cfg (cfg),
        .i_clr_sticky(clr),
        .o_valid     (o_valid),
        .o_real      (o_real),
        .o_imag      (o_imag),
        .o_shift     (o_shift),
        .o_frame_end (o_frame_end),
        .o_ovf_cnt   (o_ovf_cnt),
        .o_ovf_sticky(o_ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to check the fixed two-cycle latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Drive one valid sample; optionally queue its expected output.
    task automatic send(input int r, input int i, input int er, input int ei,
                        input int sh, input int fe, input int cnt, input int stk,
                        input bit push);
        exp_t e;
        @(negedge clk);
        valid = 1'b1;
        re    = 16'(r);
        im    = 16'(i);
        if (push) begin
            e.re  = er;
            e.im  = ei;
            e.sh  = sh;
            e.fe  = fe;
            e.cnt = cnt;
            e.stk = stk;
            e.cyc = cyc + 1;   // edge that captures this sample
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid = 1'b0;
        end
    endtask

    // Eight identical samples forming one frame, optionally with a gap after each.
    task automatic frame8(input int r, input int i, input int er, input int ei,
                          input int sh, input int cnt_prev, input int cnt_end,
                          input int stk, input bit gap);
        for (int k = 0; k < 8; k++) begin
            send(r, i, er, ei, sh, (k == 7) ? 1 : 0, (k == 7) ? cnt_end : cnt_prev, stk, 1'b1);
            if (gap && k < 7) idle(1);
        end
    endtask

    // Output monitor: one expected record per o_valid beat.
    always @(negedge clk) begin
        if (mon_en && o_valid) begin
            if (exp_q.size() == 0) begin
                check("unexp_valid", 1, 0);
            end else begin
                me = exp_q.pop_front();
                check("real",  int'($signed(o_real)), me.re);
                check("imag",  int'($signed(o_imag)), me.im);
                check("shift", int'(o_shift), me.sh);
                check("fend",  int'(o_frame_end), me.fe);
                check("ovfcnt", int'(o_ovf_cnt), me.cnt);
                check("sticky", int'(o_ovf_sticky), me.stk);
                // Output register updates one edge after the capturing edge.
                check("latency", cyc - me.cyc, 1);
            end
        end else if (mon_en) begin
            check("fend_idle", int'(o_frame_end), 0);
        end
    end

    initial begin
        rst = 1'b1; valid = 1'b0; re = 16'd0; im = 16'd0;
        auto_m = 1'b0; cfg = 3'd0; clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid",  int'(o_valid), 0);
        check("rst_real",   int'(o_real), 0);
        check("rst_shift",  int'(o_shift), 0);
        check("rst_ovfcnt", int'(o_ovf_cnt), 0);
        check("rst_sticky", int'(o_ovf_sticky), 0);
        check("rst_fend",   int'(o_frame_end), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Frame A: manual shift 0, saturation boundaries.
        send(2047, 0, 2047, 0, 0, 0, 0, 0, 1'b1);
        @(posedge clk); #1; cfg = 3'd2;        // takes effect next frame only
        send(2048, 0, 2047, 0, 0, 0, 0, 1, 1'b1);
        send(-2048, 0, -2048, 0, 0, 0, 0, 1, 1'b1);
        send(-2049, 0, -2048, 0, 0, 0, 0, 1, 1'b1);
        for (int k = 4; k < 8; k++) send(0, 0, 0, 0, 0, (k == 7) ? 1 : 0, (k == 7) ? 2 : 0, 1, 1'b1);

        // Frame B: manual shift 2, rounding; cfg=7 clamps to 4 for the next frame.
        send(4098, 8, 1025, 2, 2, 0, 2, 1, 1'b1);
        cfg = 3'd7;
        send(-6, 0, -1, 0, 2, 0, 2, 1, 1'b1);
        send(-7, 0, -2, 0, 2, 0, 2, 1, 1'b1);
        for (int k = 3; k < 8; k++) send(0, 0, 0, 0, 2, (k == 7) ? 1 : 0, (k == 7) ? 0 : 2, 1, 1'b1);
        idle(3);

        // Sticky clear while nothing saturates.
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        check("sticky_clr", int'(o_ovf_sticky), 0);

        // Frame C: shift 4; switch to auto mid-frame (no shift change mid-frame).
        cfg = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                @(posedge clk); #1; auto_m = 1'b1;
            end
            send(32767, 0, 2047, 0, 4, (k == 7) ? 1 : 0, (k == 7) ? 8 : 0, 1, 1'b1);
        end

        // Frame D: auto at MAX_SHIFT, overflowing; clear held high, set must win.
        clr = 1'b1;
        frame8(32767, 0, 2047, 0, 4, 8, 8, 1, 1'b0);
        idle(3);
        check("sticky_clr2", int'(o_ovf_sticky), 0);
        clr = 1'b0;

        // Frame E: aborted by reset after 5 samples.
        mon_en = 1'b0;
        for (int k = 0; k < 5; k++) send(32767, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        @(negedge clk); valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("mrst_valid",  int'(o_valid), 0);
        check("mrst_real",   int'(o_real), 0);
        check("mrst_shift",  int'(o_shift), 0);
        check("mrst_ovfcnt", int'(o_ovf_cnt), 0);
        check("mrst_sticky", int'(o_ovf_sticky), 0);
        check("mrst_fend",   int'(o_frame_end), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Frame F: auto, shift 0, all saturate; frame end on 8th fresh sample.
        frame8(3000, 0, 2047, 0, 0, 0, 8, 1, 1'b0);
        // Frame G: shift 1, no saturation, no headroom -> shift held.
        frame8(3000, 0, 1500, 0, 1, 8, 0, 1, 1'b0);
        // Frame H: shift 1 with input gaps, headroom -> shift drops.
        frame8(100, -100, 50, -50, 1, 0, 0, 1, 1'b1);
        // Frame I: shift 0.
        frame8(100, -100, 100, -100, 0, 0, 0, 1, 1'b0);
        idle(4);

        check("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_scale_sat_ctrl.md
Name: fft_scale_sat_ctrl

Overview:
Auto-scaling and saturation controller for the radix-2^2 FFT stage outputs. It applies a per-frame arithmetic right shift with rounding to complex samples, then saturates them from IN_WIDTH to OUT_WIDTH. It counts saturation events per frame and, in auto mode, adapts the shift at frame boundaries (block-floating-point style). It sits between a butterfly stage output and the next stage or memory write port; the applied shift travels with each sample as an exponent tag.

Parameters:
IN_WIDTH, 16, input sample width per component (two's complement)
OUT_WIDTH, 12, output sample width per component (two's complement), OUT_WIDTH < IN_WIDTH
FRAME_LEN, 64, samples per FFT frame, >= 2
MAX_SHIFT, 4, maximum right shift, < IN_WIDTH
SW, 3, shift field width, 2^SW > MAX_SHIFT
CW, 7, overflow-count width, 2^CW > FRAME_LEN

Ports:
i_clk  in  1  clock, all logic rising-edge
i_rst  in  1  reset, asynchronous, active-high
i_valid  in  1  input sample valid, no backpressure
i_real  in  IN_WIDTH  input real component
i_imag  in  IN_WIDTH  input imaginary component
i_auto  in  1  1 = adaptive shift, 0 = manual shift
i_shift_cfg  in  SW  manual shift, sampled at frame start
i_clr_sticky  in  1  clears o_ovf_sticky
o_valid  out  1  output sample valid
o_real  out  OUT_WIDTH  scaled, saturated real component
o_imag  out  OUT_WIDTH  scaled, saturated imaginary component
o_shift  out  SW  shift applied to this output sample
o_frame_end  out  1  marks last sample of a frame, qualified by o_valid
o_ovf_cnt  out  CW  saturated-sample count of last completed frame
o_ovf_sticky  out  1  sticky flag, set on any saturation

Behaviour:
- Reset: all outputs 0; cur_shift=0; sample counter=0; frame accumulators cleared. Reset mid-frame discards the partial frame, and the next valid is sample 0.
- Pipeline: latency 2 cycles, fixed. Stage1 registers the shifted value and flags. Stage2 registers the saturated output. o_valid is i_valid delayed by 2 cycles. Gaps in i_valid are allowed, and the pipeline advances every cycle.
- Scaling (stage1): work in IN_WIDTH+1 bits. v = sext(x) + (s>0 ? 2^(s-1) : 0), then y = v >>> s, using arithmetic shift with round-half-up.
- Saturation (stage2): if y > 2^(OUT_WIDTH-1)-1, output that maximum. If y < -2^(OUT_WIDTH-1), output that minimum. Otherwise output y[OUT_WIDTH-1:0].
- Sample flags (stage1, combinational on the current sample):
  - sat = real or imag out of OUT_WIDTH range.
  - head = both real and imag within [-2^(OUT_WIDTH-2), 2^(OUT_WIDTH-2)-1].
- Sample counter: increments on each i_valid, wraps FRAME_LEN-1 -> 0. The accepted sample with count FRAME_LEN-1 is "last".
- Frame accumulators: ovf_acc counts samples with sat=1, and head_acc is the AND of head across the frame. Both re-initialise on sample 0.
- Shift update, on the last-sample acceptance cycle, using flags that include that sample:
  - Auto mode, any sat in frame and cur_shift<MAX_SHIFT: cur_shift+1.
  - Auto mode, no sat, head_acc=1 and cur_shift>0: cur_shift-1.
  - Auto mode, otherwise: cur_shift is held.
  - Manual mode: cur_shift <= min(i_shift_cfg, MAX_SHIFT).
  - The first sample after reset also loads the manual value when i_auto=0.
  - The new shift applies from the next frame's sample 0, with no bubble. The shift is never changed mid-frame, including when i_auto toggles mid-frame.
- Frame status: o_frame_end=1 with o_valid on the last sample's output cycle. o_ovf_cnt is updated in that same cycle with the full-frame count and holds until the next frame end.
- o_shift is the cur_shift used for that sample, pipelined alongside the data.
- o_ovf_sticky: set on any output with sat=1, cleared by i_clr_sticky. Set wins when both occur in the same cycle.

Test Plan:
- Params 16/12/FRAME_LEN=8. Manual shift 0, real = 2047, 2048, -2048, -2049 -> o_real = 2047, 2047, -2048, -2048, 2 cycles later; o_ovf_sticky sets on the 2048 sample.
- Manual shift 2, real=4098 -> 1025; real=-6 -> -1; real=-7 -> -2; o_shift=2.
- Auto mode, frame of 8 × (3000, 0) at shift 0:
  - All outputs 2047 and o_ovf_cnt=8 with o_frame_end on sample 8.
  - The next frame uses shift 1, so 3000 -> 1500 with no saturation.
  - The shift stays 1, because 1500 exceeds the 1023 headroom limit.
- Auto mode at shift 1, frame of 8 × (100, -100) -> head_acc=1, next frame o_shift=0, output 100/-100.
- Auto mode at MAX_SHIFT=4, overflowing frame of 8 × 32767 -> shift stays 4, o_ovf_cnt=8.
- Mid-frame: assert i_rst after 5 samples -> outputs 0, next frame counts 8 fresh samples. i_clr_sticky concurrent with a saturating output -> sticky remains 1.
